// File: rtl/mul_pkg.sv
// Shared definitions for the add-shift multiplier feeder.
//  state_t   : dispatch FSM encoding
//  op_pair_t : buffered operand pair {a,b}
package mul_pkg;

    localparam int unsigned MUL_CYCLES = 8;
    localparam int unsigned OP_W       = 8;
    localparam int unsigned P_W        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data.
//  clk, rst   : clock, synchronous active-high reset (flushes contents)
//  i_push     : write i_data (ignored while full)
//  i_pop      : drop head entry (ignored while empty)
//  o_data     : current head entry, valid while !o_empty
//  o_full     : no free entry
//  o_empty    : no stored entry
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [W-1:0]  r_mem [DEPTH];
    logic          w_wr_en;
    logic          w_rd_en;

    assign w_wr_en = i_push & ~o_full;
    assign w_rd_en = i_pop & ~o_empty;

    // Extra pointer MSB distinguishes full from empty when addresses match
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/mul_dispatch.sv
// Feeder for the 8x8 add-shift multiplier.
// Buffers operand pairs, starts one multiplication per pair, holds the operands
// for the whole run and returns the product with the multiplier's accumulator
// residue removed.
//  clk, rst            : clock, synchronous active-high reset (shared with multiplier)
//  in_valid/in_ready   : operand stream handshake, in_a/in_b operands
//  mul_a/mul_b         : operands to multiplier, stable from START to capture
//  mul_start           : one-cycle start pulse
//  mul_c/mul_done      : multiplier accumulator and idle/done level
//  out_valid/out_ready : product stream handshake, out_p corrected product
//  busy                : work pending anywhere in the block
//  err                 : sticky timeout flag
module mul_dispatch
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic [OP_W-1:0] mul_a,
    output logic [OP_W-1:0] mul_b,
    output logic            mul_start,
    input  logic [P_W-1:0]  mul_c,
    input  logic            mul_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  out_p,
    output logic            busy,
    output logic            err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_pop;
    logic            w_capture;
    logic            w_timeout;
    logic            w_tmo_hit;

    logic [OP_W-1:0] r_mul_a;
    logic [OP_W-1:0] r_mul_b;
    logic            r_mul_start;
    logic [P_W-1:0]  r_out_p;
    logic            r_out_valid;
    logic [P_W-1:0]  r_prev_c;
    logic            r_err;
    logic [TMO_W-1:0] r_tmo_cnt;

    op_pair_t        w_fifo_wdata;
    op_pair_t        w_fifo_rdata;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    assign w_fifo_wdata = '{a: in_a, b: in_b};

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(op_pair_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                // Single result slot: only issue when it is free or draining now
                if (!w_fifo_empty && (!r_out_valid || out_ready)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = WAIT_LO;
            WAIT_LO: begin
                // done is still high from idle; wait for the run to actually begin
                if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!mul_done) begin
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (mul_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands, start pulse, result slot, residue tracking, timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
            r_prev_c    <= '0;
            r_err       <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            r_mul_start <= w_pop;
            if (w_pop) begin
                r_mul_a <= w_fifo_rdata.a;
                r_mul_b <= w_fifo_rdata.b;
            end

            if (r_state == WAIT_LO || r_state == WAIT_HI) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            else                                          r_tmo_cnt <= '0;

            // Multiplier keeps c across runs: final c = (old c >> 8) + a*b
            if (w_capture) begin
                r_out_p     <= mul_c - (r_prev_c >> OP_W);
                r_prev_c    <= mul_c;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign in_ready  = ~w_fifo_full;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_start = r_mul_start;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign err       = r_err;
    // Decoded from registers only
    assign busy      = (r_state != IDLE) | ~w_fifo_empty | r_out_valid;

endmodule

// File: tb/tb_mul_dispatch.sv
module tb_mul_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_start;
    logic [15:0] m_c;
    logic        m_done;
    logic [3:0]  m_cnt;
    logic        m_stuck = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_p;
    logic        busy;
    logic        err;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          n_out    = 0;
    bit          sb_en    = 1'b1;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    mul_dispatch #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_c     (m_c),
        .mul_done  (m_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .err       (err)
    );

    // Behavioural add-shift multiplier: c is not cleared on start
    always @(posedge clk) begin
        if (rst) begin
            m_c    <= '0;
            m_done <= 1'b1;
            m_cnt  <= '0;
        end else if (m_stuck) begin
            m_done <= 1'b1;
            m_cnt  <= '0;
        end else if (mul_start) begin
            m_cnt  <= 4'd8;
            m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) begin
                m_done <= 1'b1;
                m_c    <= {8'h00, m_c[15:8]} + ({8'h00, mul_a} * {8'h00, mul_b});
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected a*b queued on accept, compared on output transfer
    always @(negedge clk) begin
        logic [15:0] exp_p;
        if (!rst && in_valid && in_ready && sb_en)
            sb_q.push_back({8'h00, in_a} * {8'h00, in_b});
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_p = sb_q.pop_front();
                check("out_p", int'(out_p), int'(exp_p));
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("push_timeout", 0, 1);
    endtask

    task automatic drain(input int max_cyc);
        for (int t = 0; t < max_cyc; t++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && !busy) return;
        end
        check("drain_timeout", 0, 1);
    endtask

    initial begin
        int vk;
        int sk;
        int starts;
        int n0;
        int k;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_p", int'(out_p), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_mul_start", int'(mul_start), 0);
        check("rst_mul_ab", int'({mul_a, mul_b}), 0);

        // Single product, latency and start pulse
        out_ready = 1'b1;
        push(8'd100, 8'd65);
        vk = 0; sk = 0; starts = 0;
        for (int t = 1; t <= 30 && vk == 0; t++) begin
            @(posedge clk);
            #1;
            if (mul_start) begin
                starts++;
                sk = t;
            end
            if (out_valid) begin
                vk = t;
                check("first_out_p", int'(out_p), 6500);
            end
        end
        check("out_latency", vk + 1, 12);
        check("start_count", starts, 1);
        check("start_cycle", sk, 1);
        drain(50);

        // Back-to-back with residue correction
        push(8'd100, 8'd65);
        push(8'd3, 8'd7);
        drain(100);

        // Full-scale operands twice
        push(8'd255, 8'd255);
        push(8'd255, 8'd255);
        drain(100);

        // Back-pressure: single slot plus full FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(2 * i + 1), 8'(2 * i + 2));
        repeat (2) @(posedge clk);
        #1;
        check("bp_in_ready_low", int'(in_ready), 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp_out_valid", int'(out_valid), 1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_p", int'(out_p), 2);
        check("bp_hold_in_ready", int'(in_ready), 0);
        n0 = n_out;
        out_ready = 1'b1;
        drain(200);
        check("bp_count", n_out - n0, 5);

        // Reset during WAIT_HI drops the pair
        push(8'd9, 8'd9);
        repeat (5) @(posedge clk);
        #1;
        n0 = n_out;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_out", n_out - n0, 0);
        push(8'd2, 8'd3);
        drain(50);

        // Timeout with done stuck high
        m_stuck = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_out;
        sb_en = 1'b0;
        push(8'd4, 8'd4);
        sb_en = 1'b1;
        k = 0;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk);
            #1;
            if (t == 10) check("tmo_err_early", int'(err), 0);
            if (err) begin
                k = t;
                break;
            end
        end
        check("tmo_latency", k, 17);
        check("tmo_busy", int'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        check("tmo_sticky", int'(err), 1);
        check("tmo_no_out", n_out - n0, 0);

        // Recovery without reset; residue tracking unaffected by the timeout
        m_stuck = 1'b0;
        @(posedge clk);
        #1;
        push(8'd6, 8'd7);
        drain(50);
        check("tmo_sticky_after", int'(err), 1);

        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("err_cleared", int'(err), 0);

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

endmodule
